// File: rtl/f32m_inv_pkg.sv
// Shared GF(3^M) definitions: element widths (WIDTH/W2 macros), FSM states and trit arithmetic.
// Elements hold 2 bits per trit (00=0, 01=1, 10=2), trit i at bits [2i+1:2i]; field modulus x^5 + 2x + 1.
`ifndef F32M_INC_V
`define F32M_INC_V
`define WIDTH 9
`define W2 19
`endif

package f32m_inv_pkg;
  localparam int M  = 5;
  localparam int EW = `WIDTH + 1;
  localparam int XW = `W2 + 1;

  // Inversion by Fermat: a^(3^M - 2), one exponent bit per cycle
  localparam int INV_EXP  = 3**M - 2;
  localparam int INV_BITS = $clog2(INV_EXP + 1);

  // Cycles from a sub-unit's reset release to its done rising
  localparam int L_MULT = M;
  localparam int L_INV  = INV_BITS;

  typedef enum logic [1:0] {
    S_SQ   = 2'd0,
    S_INV  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef logic [EW-1:0] f3m_t;

  // x^M reduces to x + 2
  localparam f3m_t RED = 10'b00_00_00_01_10;

  function automatic logic [1:0] f3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [1:0] f3_mul(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd0 || y == 2'd0) return 2'd0;
    return (x == y) ? 2'd1 : 2'd2;
  endfunction

  function automatic f3m_t f3m_add(input f3m_t x, input f3m_t y);
    f3m_t r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = f3_add(x[2*i +: 2], y[2*i +: 2]);
    return r;
  endfunction

  function automatic f3m_t f3m_neg(input f3m_t x);
    f3m_t r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = {x[2*i], x[2*i+1]};
    return r;
  endfunction

  function automatic f3m_t f3m_scale(input f3m_t x, input logic [1:0] t);
    f3m_t r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = f3_mul(x[2*i +: 2], t);
    return r;
  endfunction

  function automatic f3m_t f3m_mulx(input f3m_t x);
    return f3m_add({x[EW-3:0], 2'b00}, f3m_scale(RED, x[EW-1:EW-2]));
  endfunction

  function automatic f3m_t f3m_mul(input f3m_t x, input f3m_t y);
    f3m_t acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) acc = f3m_add(f3m_mulx(acc), f3m_scale(x, y[2*i +: 2]));
    return acc;
  endfunction
endpackage

// File: rtl/f32m_inv_mulpair.sv
// Two GF(3^M) multipliers sharing one reset; squares (a0r^2, a1r^2) or scales by dinv in S_MUL.
// Latency L_MULT from reset release; both_done is the AND of the two sticky done flags.
module f32m_inv_mulpair import f32m_inv_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  state_t          state,
  input  logic [`WIDTH:0] a0r,
  input  logic [`WIDTH:0] a1r,
  input  logic [`WIDTH:0] dinv,
  output logic [`WIDTH:0] m0,
  output logic [`WIDTH:0] m1,
  output logic            both_done
);
  f3m_t b0;
  f3m_t b1;
  logic done0;
  logic done1;

  always_comb begin
    b0 = a0r;
    b1 = a1r;
    if (state == S_MUL) begin
      b0 = dinv;
      b1 = dinv;
    end
  end

  f3m_mult u_mult0 (
    .clk  (clk),
    .reset(reset),
    .a    (a0r),
    .b    (b0),
    .c    (m0),
    .done (done0)
  );

  f3m_mult u_mult1 (
    .clk  (clk),
    .reset(reset),
    .a    (a1r),
    .b    (b1),
    .c    (m1),
    .done (done1)
  );

  assign both_done = done0 & done1;
endmodule

// File: rtl/f3m_arith.sv
// Sequential GF(3^M) multiplier (M cycles, one trit of b per cycle) and inverter (INV_BITS cycles).
// Both start on reset release, hold done sticky, and require operands stable until done.
module f3m_mult import f32m_inv_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic [`WIDTH:0] a,
  input  logic [`WIDTH:0] b,
  output logic [`WIDTH:0] c,
  output logic            done
);
  localparam int IW = $clog2(M);

  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      c    <= '0;
      idx  <= IW'(M - 1);
      done <= 1'b0;
    end else if (!done) begin
      c <= f3m_add(f3m_mulx(c), f3m_scale(a, b[2*idx +: 2]));
      if (idx == '0) done <= 1'b1;
      else           idx  <= idx - 1'b1;
    end
  end
endmodule

module f3m_inv import f32m_inv_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic [`WIDTH:0] a,
  output logic [`WIDTH:0] c,
  output logic            done
);
  localparam int IB = $clog2(INV_BITS);
  localparam logic [INV_BITS-1:0] EXP_V = INV_BITS'(INV_EXP);

  logic [IB-1:0] idx;
  f3m_t          sq;

  assign sq = f3m_mul(c, c);

  // MSB-first square-and-multiply; a = 0 naturally yields 0
  always_ff @(posedge clk) begin
    if (reset) begin
      c    <= EW'(1);
      idx  <= IB'(INV_BITS - 1);
      done <= 1'b0;
    end else if (!done) begin
      c <= EXP_V[idx] ? f3m_mul(sq, a) : sq;
      if (idx == '0) done <= 1'b1;
      else           idx  <= idx - 1'b1;
    end
  end
endmodule

// File: rtl/f32m_inv.sv
// GF(3^{2M}) inverter c = (a0 - a1*i)/(a0^2 + a1^2); done after 2*L_MULT + L_INV + 4 cycles, sticky.
// F32M_INV_ZERO_FLAG_EN adds a sticky zero output and a 1-cycle shortcut for a = 0.
module f32m_inv import f32m_inv_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic [`W2:0] a,
  output logic [`W2:0] c,
  output logic         done
`ifdef F32M_INV_ZERO_FLAG_EN
  ,
  output logic         zero
`endif
);
  state_t state;
  f3m_t   a0r;
  f3m_t   a1r;
  f3m_t   d;
  f3m_t   dinv;
  f3m_t   m0;
  f3m_t   m1;
  f3m_t   inv_c;
  logic   mult_rst;
  logic   inv_rst;
  logic   mul_done;
  logic   inv_done;
  logic   zero_start;

  f32m_inv_mulpair u_mulpair (
    .clk      (clk),
    .reset    (mult_rst),
    .state    (state),
    .a0r      (a0r),
    .a1r      (a1r),
    .dinv     (dinv),
    .m0       (m0),
    .m1       (m1),
    .both_done(mul_done)
  );

  f3m_inv u_inv (
    .clk  (clk),
    .reset(inv_rst),
    .a    (d),
    .c    (inv_c),
    .done (inv_done)
  );

`ifdef F32M_INV_ZERO_FLAG_EN
  assign zero_start = mult_rst && (state == S_SQ) && (a0r == '0) && (a1r == '0);

  always_ff @(posedge clk) begin
    if (reset)           zero <= 1'b0;
    else if (zero_start) zero <= 1'b1;
  end
`else
  assign zero_start = 1'b0;
`endif

  // Idle sub-units are held in reset; releasing the reset starts them, so a
  // stale done from the previous phase can only be seen in the first S_SQ cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_SQ;
      done     <= 1'b0;
      c        <= '0;
      mult_rst <= 1'b1;
      inv_rst  <= 1'b1;
      a0r      <= a[`WIDTH:0];
      a1r      <= a[`W2:`WIDTH+1];
      d        <= '0;
      dinv     <= '0;
    end else begin
      case (state)
        S_SQ: begin
          mult_rst <= 1'b0;
          if (zero_start) begin
            done     <= 1'b1;
            mult_rst <= 1'b1;
            state    <= S_DONE;
          end else if (mul_done && !mult_rst) begin
            d        <= f3m_add(m0, m1);
            inv_rst  <= 1'b0;
            mult_rst <= 1'b1;
            state    <= S_INV;
          end
        end
        S_INV: begin
          if (inv_done) begin
            dinv     <= inv_c;
            inv_rst  <= 1'b1;
            mult_rst <= 1'b0;
            state    <= S_MUL;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            c        <= {f3m_neg(m1), m0};
            done     <= 1'b1;
            mult_rst <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_f32m_inv.sv
// Randomized bench for f32m_inv against an integer GF(3^5)/GF(3^10) model (modulus x^5 + 2x + 1).
// Inverses come from a brute-force table; results are also multiplied back by a and compared with 1.
module tb_f32m_inv;
  import f32m_inv_pkg::*;

  localparam int Q       = 3**M;
  localparam int EXP_LAT = 2 * L_MULT + L_INV + 4;
  localparam int MAX_LAT = 400;

  logic          clk = 1'b0;
  logic          reset;
  logic [XW-1:0] a;
  logic [XW-1:0] c;
  logic          done;
`ifdef F32M_INV_ZERO_FLAG_EN
  logic          zero;
`endif

  int checks   = 0;
  int failures = 0;
  int inv_tab[Q];

  always #5 clk = ~clk;

  f32m_inv dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .c    (c),
    .done (done)
`ifdef F32M_INV_ZERO_FLAG_EN
    ,
    .zero (zero)
`endif
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- reference model: elements are integers 0..Q-1, base-3 digits are coefficients
  function automatic int gf_mul(input int x, input int y);
    int xs[M];
    int ys[M];
    int p[2*M-1];
    int r;
    int pw;
    for (int i = 0; i < M; i++) begin
      xs[i] = x % 3; x = x / 3;
      ys[i] = y % 3; y = y / 3;
    end
    for (int k = 0; k < 2*M-1; k++) p[k] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) p[i+j] += xs[i] * ys[j];
    for (int k = 2*M-2; k >= M; k--) begin
      p[k-M+1] += p[k];
      p[k-M]   += 2 * p[k];
    end
    r = 0; pw = 1;
    for (int i = 0; i < M; i++) begin
      r += (p[i] % 3) * pw;
      pw *= 3;
    end
    return r;
  endfunction

  function automatic int gf_lin(input int x, input int y, input int ky);
    int r;
    int pw;
    r = 0; pw = 1;
    for (int i = 0; i < M; i++) begin
      r += ((x % 3 + ky * (y % 3)) % 3) * pw;
      x = x / 3; y = y / 3; pw *= 3;
    end
    return r;
  endfunction

  function automatic int gf_add(input int x, input int y); return gf_lin(x, y, 1); endfunction
  function automatic int gf_sub(input int x, input int y); return gf_lin(x, y, 2); endfunction
  function automatic int gf_neg(input int x);              return gf_lin(0, x, 2); endfunction

  function automatic logic [EW-1:0] enc(input int v);
    logic [EW-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      r[2*i +: 2] = 2'(v % 3);
      v = v / 3;
    end
    return r;
  endfunction

  function automatic int dec(input logic [EW-1:0] e);
    int v;
    int pw;
    v = 0; pw = 1;
    for (int i = 0; i < M; i++) begin
      v += int'(e[2*i +: 2]) * pw;
      pw *= 3;
    end
    return v;
  endfunction

  // ---- stimulus helpers
  task automatic apply_reset(input int a0v, input int a1v);
    @(negedge clk);
    reset = 1'b1;
    a     = {enc(a1v), enc(a0v)};
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_c", c, 0);
`ifdef F32M_INV_ZERO_FLAG_EN
    check("rst_zero", zero, 0);
`endif
    reset = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    logic moved;
    moved = 1'b0;
    lat   = 0;
    while (!done && lat < MAX_LAT) begin
      @(negedge clk);
      lat++;
      if (!done && c != '0) moved = 1'b1;
    end
    check("c_early", moved, 0);
    check("done_seen", done, 1);
  endtask

  task automatic check_result(input string tag, input int a0v, input int a1v, input int lat);
    int d, di, c0e, c1e, c0, c1, re, im, exp_lat;
    d   = gf_add(gf_mul(a0v, a0v), gf_mul(a1v, a1v));
    di  = inv_tab[d];
    c0e = gf_mul(a0v, di);
    c1e = gf_neg(gf_mul(a1v, di));
    exp_lat = EXP_LAT;
`ifdef F32M_INV_ZERO_FLAG_EN
    if (a0v == 0 && a1v == 0) exp_lat = 1;
    check({tag, "_zero"}, zero, (a0v == 0 && a1v == 0) ? 1 : 0);
`endif
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_c"}, c, {enc(c1e), enc(c0e)});
    if (a0v != 0 || a1v != 0) begin
      c0 = dec(c[EW-1:0]);
      c1 = dec(c[XW-1:EW]);
      re = gf_sub(gf_mul(c0, a0v), gf_mul(c1, a1v));
      im = gf_add(gf_mul(c0, a1v), gf_mul(c1, a0v));
      check({tag, "_prod_re"}, re, 1);
      check({tag, "_prod_im"}, im, 0);
    end
  endtask

  task automatic run_op(input string tag, input int a0v, input int a1v);
    int lat;
    apply_reset(a0v, a1v);
    wait_done(lat);
    check_result(tag, a0v, a1v, lat);
  endtask

  initial begin
    int a0v, a1v, lat;
    logic [XW-1:0] held;

    inv_tab[0] = 0;
    for (int x = 1; x < Q; x++)
      for (int y = 1; y < Q; y++)
        if (gf_mul(x, y) == 1) inv_tab[x] = y;

    reset = 1'b1;
    a     = '0;
    repeat (3) @(negedge clk);
    check("init_done", done, 0);
    check("init_c", c, 0);
`ifdef F32M_INV_ZERO_FLAG_EN
    check("init_zero", zero, 0);
`endif

    // a = 1: result 1, then done and c hold
    run_op("one", 1, 0);
    check("one_lit", c, {enc(0), enc(1)});
    held = c;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("hold_done", done, 1);
      check("hold_c", c, held);
    end

    // a = i: inverse is -i
    run_op("i", 0, 1);
    check("i_lit", c, {enc(2), enc(0)});

    // a = 1 + i: inverse is -1 + i
    run_op("1pi", 1, 1);
    check("1pi_lit", c, {enc(1), enc(2)});

    // a = 0
    run_op("zero", 0, 0);
    check("zero_lit", c, 0);

    // reset while the inverter is running, with a new operand
    apply_reset(7, 100);
    repeat (L_MULT + 4) @(negedge clk);
    check("mid_busy", done, 0);
    apply_reset(55, 201);
    wait_done(lat);
    check_result("mid", 55, 201, lat);

    for (int n = 0; n < 1000; n++) begin
      do begin
        a0v = int'($urandom_range(0, Q - 1));
        a1v = int'($urandom_range(0, Q - 1));
      end while (a0v == 0 && a1v == 0);
      run_op("rnd", a0v, a1v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
